// File: rtl/id_rsp_reorder_if.sv
// Bus bundle for id_rsp_reorder: request tag capture, response in,
// ordered response out, per-ID release and sticky error flags.
interface id_rsp_reorder_if #(
  parameter int ID_W   = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic              req_hsk_i;
  logic [ID_W-1:0]   req_id_i;
  logic [TAG_W-1:0]  req_tag_i;
  logic              req_full_o;
  logic              rsp_vld_i;
  logic              rsp_rdy_o;
  logic [ID_W-1:0]   rsp_id_i;
  logic [TAG_W-1:0]  rsp_tag_i;
  logic [DATA_W-1:0] rsp_data_i;
  logic              out_vld_o;
  logic              out_rdy_i;
  logic [ID_W-1:0]   out_id_o;
  logic [TAG_W-1:0]  out_tag_o;
  logic [DATA_W-1:0] out_data_o;
  logic              rls_hsk_o;
  logic [ID_W-1:0]   rls_id_o;
  logic [1:0]        err_o;

  modport slave (
    input  req_hsk_i, req_id_i, req_tag_i, rsp_vld_i, rsp_id_i, rsp_tag_i, rsp_data_i, out_rdy_i,
    output req_full_o, rsp_rdy_o, out_vld_o, out_id_o, out_tag_o, out_data_o, rls_hsk_o, rls_id_o,
           err_o
  );
  modport master (
    output req_hsk_i, req_id_i, req_tag_i, rsp_vld_i, rsp_id_i, rsp_tag_i, rsp_data_i, out_rdy_i,
    input  req_full_o, rsp_rdy_o, out_vld_o, out_id_o, out_tag_o, out_data_o, rls_hsk_o, rls_id_o,
           err_o
  );
endinterface

// File: rtl/id_rsp_reorder.sv
// Response reorder buffer: per-ID tag FIFOs record issue order, a small
// response buffer releases responses so each ID leaves in issue order.
module id_rsp_reorder_tagq #(
  parameter int OUST_N = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] head_o,
  output logic             nonempty_o,
  output logic             full_o,
  output logic             drop_o
);
  localparam int PTR_W = (OUST_N > 1) ? $clog2(OUST_N) : 1;
  localparam int CNT_W = $clog2(OUST_N + 1);

  logic [OUST_N-1:0][TAG_W-1:0] mem_q;
  logic [PTR_W-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         do_push;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUST_N - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (cnt_q == CNT_W'(OUST_N));
  assign nonempty_o = (cnt_q != '0);
  assign head_o     = mem_q[rptr_q];
  // a same-cycle pop frees the slot, so a push into a full FIFO still lands
  assign do_push    = push_i && (!full_o || pop_i);
  assign drop_o     = push_i && full_o && !pop_i;

  always_comb begin
    wptr_d = do_push ? nxt(wptr_q) : wptr_q;
    rptr_d = pop_i   ? nxt(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CNT_W'(do_push) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) mem_q[wptr_q] <= tag_i;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module id_rsp_reorder #(
  parameter int ID_W   = 2,
  parameter int OUST_N = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int BUF_N  = 4
) (
  input logic             clk,
  input logic             rst_n,
  id_rsp_reorder_if.slave bus
);
  localparam int NUM_ID = 1 << ID_W;
  localparam int SEL_W  = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic [NUM_ID-1:0]            push, pop, nonempty, full, drop;
  logic [NUM_ID-1:0][TAG_W-1:0] head;

  logic [BUF_N-1:0] vld_q, vld_d, elig;
  ent_t [BUF_N-1:0] ent_q;
  ent_t             sel_ent;
  logic [SEL_W-1:0] free_idx, sel_idx;
  logic             any_free, any_elig, rsp_acc, out_hsk;
  logic             rls_hsk_q;
  logic [ID_W-1:0]  rls_id_q, rls_id_d;
  logic [1:0]       err_q, err_d;

  for (genvar g = 0; g < NUM_ID; g++) begin : g_id
    assign push[g] = bus.req_hsk_i && (bus.req_id_i == ID_W'(g));
    assign pop[g]  = out_hsk && (sel_ent.id == ID_W'(g));
    id_rsp_reorder_tagq #(.OUST_N(OUST_N), .TAG_W(TAG_W)) u_tagq (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push[g]),
      .tag_i      (bus.req_tag_i),
      .pop_i      (pop[g]),
      .head_o     (head[g]),
      .nonempty_o (nonempty[g]),
      .full_o     (full[g]),
      .drop_o     (drop[g])
    );
  end

  // eligibility comes from registered state only, so no same-cycle bypass
  for (genvar b = 0; b < BUF_N; b++) begin : g_buf
    assign elig[b] = vld_q[b] && nonempty[ent_q[b].id] && (ent_q[b].tag == head[ent_q[b].id]);
  end

  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    any_free = 1'b0;
    any_elig = 1'b0;
    for (int b = BUF_N - 1; b >= 0; b--) begin
      if (!vld_q[b]) begin
        free_idx = SEL_W'(b);
        any_free = 1'b1;
      end
      if (elig[b]) begin
        sel_idx  = SEL_W'(b);
        any_elig = 1'b1;
      end
    end
  end

  assign sel_ent = ent_q[sel_idx];
  assign rsp_acc = bus.rsp_vld_i && any_free;
  assign out_hsk = any_elig && bus.out_rdy_i;

  always_comb begin
    vld_d = vld_q;
    if (out_hsk) vld_d[sel_idx]  = 1'b0;
    if (rsp_acc) vld_d[free_idx] = 1'b1;
    rls_id_d = out_hsk ? sel_ent.id : rls_id_q;
    err_d    = err_q | {rsp_acc && !nonempty[bus.rsp_id_i], |drop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      ent_q     <= '0;
      rls_hsk_q <= 1'b0;
      rls_id_q  <= '0;
      err_q     <= '0;
    end else begin
      vld_q <= vld_d;
      if (rsp_acc) ent_q[free_idx] <= '{id: bus.rsp_id_i, tag: bus.rsp_tag_i, data: bus.rsp_data_i};
      rls_hsk_q <= out_hsk;
      rls_id_q  <= rls_id_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_full_o = full[bus.req_id_i];
  assign bus.rsp_rdy_o  = any_free;
  assign bus.out_vld_o  = any_elig;
  assign {bus.out_id_o, bus.out_tag_o, bus.out_data_o} = any_elig ? sel_ent : '0;
  assign bus.rls_hsk_o  = rls_hsk_q;
  assign bus.rls_id_o   = rls_id_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_id_rsp_reorder.sv
// Bench for id_rsp_reorder: cycle table for ordering cases, hand sequences
// for full/backpressure/error/reset, scoreboard on the ordered output.
module tb_id_rsp_reorder;
  localparam int ID_W = 2, OUST_N = 4, TAG_W = 4, DATA_W = 32, BUF_N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_rsp_reorder_if #(.ID_W(ID_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();
  id_rsp_reorder #(.ID_W(ID_W), .OUST_N(OUST_N), .TAG_W(TAG_W), .DATA_W(DATA_W), .BUF_N(BUF_N))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int id; int tag; int data; } exp_t;
  // op: 0 idle, 1 request push, 2 response; sbv pushes {bid,btag,bdata} as next expected output
  typedef struct { int op; int id; int tag; int data; int ovld; int otag;
                   int sbv; int bid; int btag; int bdata; } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_chk = 0, n_pass = 0;
  bit   mon_en = 1'b0;
  bit   pend = 1'b0;
  int   pend_id = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic add(input int op, id, tag, data, ovld, otag, sbv, bid, btag, bdata);
    vec_t r;
    r = '{op, id, tag, data, ovld, otag, sbv, bid, btag, bdata};
    vecs.push_back(r);
  endtask

  task automatic idle_in();
    bus.req_hsk_i = 1'b0; bus.req_id_i = '0; bus.req_tag_i = '0;
    bus.rsp_vld_i = 1'b0; bus.rsp_id_i = '0; bus.rsp_tag_i = '0; bus.rsp_data_i = '0;
  endtask

  task automatic drive_rsp(input int id, input int tag, input int data);
    bus.rsp_vld_i = 1'b1; bus.rsp_id_i = ID_W'(id); bus.rsp_tag_i = TAG_W'(tag);
    bus.rsp_data_i = DATA_W'(data);
  endtask

  task automatic sb_push(input int id, input int tag, input int data);
    exp_t e;
    e = '{id, tag, data};
    sb.push_back(e);
  endtask

  task automatic reset_chk(input string nm);
    chk({nm, "_rsp_rdy"}, bus.rsp_rdy_o, 1);
    chk({nm, "_out_vld"}, bus.out_vld_o, 0);
    chk({nm, "_out_id"}, bus.out_id_o, 0);
    chk({nm, "_out_tag"}, bus.out_tag_o, 0);
    chk({nm, "_out_data"}, bus.out_data_o, 0);
    chk({nm, "_rls_hsk"}, bus.rls_hsk_o, 0);
    chk({nm, "_rls_id"}, bus.rls_id_o, 0);
    chk({nm, "_err"}, bus.err_o, 0);
    chk({nm, "_req_full"}, bus.req_full_o, 0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin step(); n++; end
    chk({nm, "_drained"}, sb.size(), 0);
    repeat (2) step();
  endtask

  // output scoreboard and release check
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        chk("rls_hsk", bus.rls_hsk_o, 1);
        chk("rls_id", bus.rls_id_o, pend_id);
      end else if (bus.rls_hsk_o) chk("rls_spurious", bus.rls_hsk_o, 0);
      pend = 1'b0;
      if (bus.out_vld_o && bus.out_rdy_i) begin
        if (sb.size() == 0) chk("out_unexpected", bus.out_vld_o, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_id", bus.out_id_o, e.id);
          chk("out_tag", bus.out_tag_o, e.tag);
          chk("out_data", bus.out_data_o, e.data);
          pend = 1'b1;
          pend_id = e.id;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    idle_in();
    bus.out_rdy_i = 1'b0;
    #12 reset_chk("reset");
    @(negedge clk) rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    bus.out_rdy_i = 1'b1;

    // in-order single ID
    add(1, 1, 3, 0,     0, 0, 1, 1, 3, 'hA);
    add(1, 1, 5, 0,     0, 0, 1, 1, 5, 'hB);
    add(2, 1, 3, 'hA,   0, 0, 0, 0, 0, 0);
    add(2, 1, 5, 'hB,   1, 3, 0, 0, 0, 0);
    add(0, 0, 0, 0,     1, 5, 0, 0, 0, 0);
    add(0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    // out-of-order same ID
    add(1, 2, 1, 0,     0, 0, 1, 2, 1, 'h31);
    add(1, 2, 2, 0,     0, 0, 1, 2, 2, 'h32);
    add(1, 2, 3, 0,     0, 0, 1, 2, 3, 'h33);
    add(2, 2, 3, 'h33,  0, 0, 0, 0, 0, 0);
    add(2, 2, 2, 'h32,  0, 0, 0, 0, 0, 0);
    add(2, 2, 1, 'h31,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,     1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,     1, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0,     1, 3, 0, 0, 0, 0);
    add(0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    // cross-ID independence
    add(1, 0, 4, 0,     0, 0, 1, 3, 7, 'h37);
    add(1, 0, 6, 0,     0, 0, 1, 0, 4, 'h04);
    add(1, 3, 7, 0,     0, 0, 1, 0, 6, 'h06);
    add(2, 0, 6, 'h06,  0, 0, 0, 0, 0, 0);
    add(2, 3, 7, 'h37,  0, 0, 0, 0, 0, 0);
    add(2, 0, 4, 'h04,  1, 7, 0, 0, 0, 0);
    add(0, 0, 0, 0,     1, 4, 0, 0, 0, 0);
    add(0, 0, 0, 0,     1, 6, 0, 0, 0, 0);
    add(0, 0, 0, 0,     0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      idle_in();
      if (vecs[i].op == 1) begin
        bus.req_hsk_i = 1'b1; bus.req_id_i = ID_W'(vecs[i].id); bus.req_tag_i = TAG_W'(vecs[i].tag);
      end else if (vecs[i].op == 2) drive_rsp(vecs[i].id, vecs[i].tag, vecs[i].data);
      if (vecs[i].sbv != 0) sb_push(vecs[i].bid, vecs[i].btag, vecs[i].bdata);
      @(negedge clk);
      chk($sformatf("v%0d_out_vld", i), bus.out_vld_o, vecs[i].ovld);
      if (vecs[i].ovld != 0) chk($sformatf("v%0d_out_tag", i), bus.out_tag_o, vecs[i].otag);
      chk($sformatf("v%0d_rsp_rdy", i), bus.rsp_rdy_o, 1);
      chk($sformatf("v%0d_req_full", i), bus.req_full_o, 0);
      chk($sformatf("v%0d_err", i), bus.err_o, 0);
      step();
    end
    idle_in();
    drain("table");

    // full FIFO: 5 pushes to ID0, the 5th is dropped
    bus.out_rdy_i = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      bus.req_hsk_i = 1'b1; bus.req_id_i = '0; bus.req_tag_i = TAG_W'(t);
      @(negedge clk);
      chk($sformatf("push%0d_full", t), bus.req_full_o, (t == 5) ? 1 : 0);
      step();
    end
    idle_in();
    @(negedge clk);
    chk("drop_err", bus.err_o, 2'b01);
    step();

    // fill the response buffer while output is stalled
    for (int t = 1; t <= 4; t++) begin
      drive_rsp(0, t, 'hD0 + t);
      sb_push(0, t, 'hD0 + t);
      @(negedge clk);
      chk($sformatf("fill%0d_rdy", t), bus.rsp_rdy_o, 1);
      step();
    end
    idle_in();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_rsp_rdy", k), bus.rsp_rdy_o, 0);
      chk($sformatf("bp%0d_out_vld", k), bus.out_vld_o, 1);
      chk($sformatf("bp%0d_out_id", k), bus.out_id_o, 0);
      chk($sformatf("bp%0d_out_tag", k), bus.out_tag_o, 1);
      chk($sformatf("bp%0d_out_data", k), bus.out_data_o, 'hD1);
      step();
    end

    // push and pop on the full ID in the same cycle
    bus.out_rdy_i = 1'b1;
    bus.req_hsk_i = 1'b1; bus.req_id_i = '0; bus.req_tag_i = TAG_W'(9);
    @(negedge clk);
    chk("simul_full_before", bus.req_full_o, 1);
    step();
    idle_in();
    @(negedge clk);
    chk("simul_full_after", bus.req_full_o, 1);
    chk("simul_err", bus.err_o, 2'b01);
    chk("freed_rsp_rdy", bus.rsp_rdy_o, 1);
    step();
    drive_rsp(0, 9, 'hD9);
    sb_push(0, 9, 'hD9);
    step();
    idle_in();
    drain("full");
    @(negedge clk);
    chk("full_done_vld", bus.out_vld_o, 0);
    chk("full_done_full", bus.req_full_o, 0);
    chk("full_done_rdy", bus.rsp_rdy_o, 1);
    step();

    // unexpected responses to empty ID1 are stored but never leave
    drive_rsp(1, 7, 'h77);
    @(negedge clk);
    chk("unexp_acc_vld", bus.out_vld_o, 0);
    step();
    idle_in();
    @(negedge clk);
    chk("unexp_err", bus.err_o, 2'b11);
    chk("unexp_out_vld", bus.out_vld_o, 0);
    chk("unexp_rsp_rdy", bus.rsp_rdy_o, 1);
    step();
    for (int t = 8; t <= 10; t++) begin
      drive_rsp(1, t, 'h70 + t);
      step();
    end
    idle_in();
    @(negedge clk);
    chk("unexp_held_rdy", bus.rsp_rdy_o, 0);
    chk("unexp_held_vld", bus.out_vld_o, 0);
    step();

    // asynchronous reset mid-stream
    mon_en = 1'b0;
    pend = 1'b0;
    rst_n = 1'b0;
    #2 reset_chk("midrst");
    @(negedge clk) rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // post-reset sanity transaction
    bus.req_hsk_i = 1'b1; bus.req_id_i = 2'd2; bus.req_tag_i = TAG_W'(5);
    sb_push(2, 5, 'h25);
    step();
    idle_in();
    drive_rsp(2, 5, 'h25);
    step();
    idle_in();
    drain("postrst");
    @(negedge clk);
    chk("postrst_err", bus.err_o, 0);
    chk("postrst_vld", bus.out_vld_o, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
